// File: rtl/ama_riscv_icache.sv
// ama_riscv_icache
// Direct-mapped, read-only instruction cache between the fetch stage and the
// imem port of main memory. Hits return a 32-bit word the cycle after accept;
// misses fetch a whole 128-bit line, fill it, then return the requested word.
// A single-cycle inv pulse invalidates every line (fence.i).
//
// Optional feature macro: ICACHE_STATS_EN adds hit_cnt / miss_cnt outputs.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   req_valid/ready    fetch request handshake, req_addr = byte address
//   rsp_valid/data     one-cycle response pulse with the instruction word
//   inv                invalidate-all pulse
//   mem_req_*          line request to memory (line address)
//   mem_rsp_*          line data from memory (word k in bits [32k+31:32k])
//   hit_cnt, miss_cnt  accepted hit/miss counters (ICACHE_STATS_EN only)
//   fsm_state          current controller state, for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The requester holds valid and payload stable until that edge; ready may
// depend combinationally on inv but never on valid. Responses carry no ready:
// the consumer must take every rsp_valid pulse.
module ama_riscv_icache #(
  parameter int SETS        = 16,
  parameter int LINE_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_data,
  input  logic                   inv,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [LINE_ADDR_W-1:0] mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [127:0]           mem_rsp_data,
`ifdef ICACHE_STATS_EN
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt,
`endif
  output logic [1:0]             fsm_state
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = LINE_ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  state_t state;

  // Storage: valid bits are reset, tag and data arrays are not.
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [127:0]     data_q [SETS];

  // Latched miss address and a deferred invalidate seen during a miss.
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [1:0]       miss_off;
  logic             inv_pend;

  // Request address split
  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_addr_bits;

  assign req_off = req_addr[3:2];
  assign req_idx = req_addr[IDX_W+3:4];
  assign req_tag = req_addr[LINE_ADDR_W+3:IDX_W+4];
  assign unused_addr_bits = ^{req_addr[31:LINE_ADDR_W+4], req_addr[1:0]};

  logic        hit;
  logic [31:0] hit_word;
  logic [31:0] fill_word;
  logic        accept;
  logic        fill;

  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word  = data_q[req_idx][{req_off, 5'b0} +: 32];
  assign fill_word = mem_rsp_data[{miss_off, 5'b0} +: 32];

  // A pending invalidate costs one IDLE cycle with req_ready low while the
  // clear is applied, so no lookup can see the line that was just filled.
  assign req_ready = (state == IDLE) && !inv && !inv_pend;
  assign accept    = req_valid && req_ready;
  assign fill      = (state == MISS_WAIT) && mem_rsp_valid;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      valid_q       <= '0;
      inv_pend      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      miss_idx      <= '0;
      miss_tag      <= '0;
      miss_off      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (inv || inv_pend) begin
            valid_q  <= '0;
            inv_pend <= 1'b0;
          end else if (accept) begin
            if (hit) begin
              rsp_valid <= 1'b1;
              rsp_data  <= hit_word;
            end else begin
              miss_idx      <= req_idx;
              miss_tag      <= req_tag;
              miss_off      <= req_off;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {req_tag, req_idx};
              state         <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (inv) inv_pend <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (inv) inv_pend <= 1'b1;
          if (mem_rsp_valid) begin
            valid_q[miss_idx] <= 1'b1;
            rsp_valid         <= 1'b1;
            rsp_data          <= fill_word;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line payload write; gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[miss_idx] <= mem_rsp_data;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
